// File: rtl/msk_scan_loader.sv
`default_nettype none
// ============================================================================
// Module   : msk_scan_loader
// Brief    : Serial load / core hand-off / serial unload controller for a chain
//            of masked scan registers; share data is passed through as wires.
// Revision : 1.0 - initial release
// ============================================================================
module msk_scan_loader #(
    parameter int D      = 2,
    parameter int COUNT  = 8,
    parameter int NWORDS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COUNT*D-1:0]   in_data,
    output logic [COUNT*D-1:0]   scan_in,
    input  logic [COUNT*D-1:0]   scan_out,
    output logic                 scan_en,
    output logic                 reg_en,
    output logic                 core_start,
    input  logic                 core_en,
    input  logic                 core_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COUNT*D-1:0]   out_data
);

    localparam int              c_cnt_w     = $clog2(NWORDS + 1);
    localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;

    logic w_in_load;
    logic w_in_start;
    logic w_in_run;
    logic w_in_unload;
    logic w_accept;
    logic w_deliver;

    // Decodes are gated by rst so every control output drops the instant reset rises.
    assign w_in_load   = (r_state == S_LOAD)   && !rst;
    assign w_in_start  = (r_state == S_START)  && !rst;
    assign w_in_run    = (r_state == S_RUN)    && !rst;
    assign w_in_unload = (r_state == S_UNLOAD) && !rst;

    assign w_accept  = w_in_load   && in_valid;
    assign w_deliver = w_in_unload && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_cnt == c_last_word) begin
                            r_state <= S_START;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (core_done) begin
                        r_state <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (r_cnt == c_last_word) begin
                            r_state <= S_LOAD;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Handshake-qualified strobes must act in the accept cycle, so these stay combinational.
    assign in_ready   = w_in_load;
    assign out_valid  = w_in_unload;
    assign core_start = w_in_start;
    assign scan_en    = w_accept || w_deliver;
    assign reg_en     = w_accept || w_deliver || (w_in_run && core_en);

    assign scan_in  = in_data;
    assign out_data = scan_out;

endmodule

`default_nettype wire

// File: tb/tb_msk_scan_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_msk_scan_loader
// Brief    : Self-checking bench: vector table on a one-word chain, directed and
//            randomized traffic on a sixteen-word chain against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msk_scan_loader;

    localparam int NW = 16;
    localparam int W  = 16;

    localparam int P_LOAD   = 0;
    localparam int P_START  = 1;
    localparam int P_RUN    = 2;
    localparam int P_UNLOAD = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid = 1'b0, in_ready, scan_en, reg_en, core_start;
    logic         core_en = 1'b0, core_done = 1'b0, out_valid, out_ready = 1'b0;
    logic [W-1:0] in_data = '0, scan_in, scan_out, out_data;

    logic         in_valid1 = 1'b0, in_ready1, scan_en1, reg_en1, core_start1;
    logic         core_en1 = 1'b0, core_done1 = 1'b0, out_valid1, out_ready1 = 1'b0;
    logic [W-1:0] in_data1 = '0, scan_in1, scan_out1 = '0, out_data1;

    int checks   = 0;
    int failures = 0;
    int m_phase  = P_LOAD;
    int m_cnt    = 0;
    logic [W-1:0] chain_q[$];

    logic [W-1:0] chain [NW] = '{default: '0};

    always #5 clk = ~clk;

    // Stand-in for the masked register chain: shifts only when both enables are high.
    always @(posedge clk) begin
        if (reg_en && scan_en) begin
            for (int i = NW - 1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= scan_in;
        end
    end
    assign scan_out = chain[NW-1];

    msk_scan_loader #(.D(2), .COUNT(8), .NWORDS(NW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .scan_in(scan_in), .scan_out(scan_out),
        .scan_en(scan_en), .reg_en(reg_en), .core_start(core_start),
        .core_en(core_en), .core_done(core_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    msk_scan_loader #(.D(2), .COUNT(8), .NWORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .scan_in(scan_in1), .scan_out(scan_out1),
        .scan_en(scan_en1), .reg_en(reg_en1), .core_start(core_start1),
        .core_en(core_en1), .core_done(core_done1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1)
    );

    typedef struct {
        bit iv, cen, cdone, ordy;
        bit e_ir, e_ov, e_cs, e_se, e_re;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_core_start"}, 32'(core_start), 32'd0);
        check({tag, "_scan_en"},    32'(scan_en),    32'd0);
        check({tag, "_reg_en"},     32'(reg_en),     32'd0);
    endtask

    // One clock of the 16-word DUT, checked against the phase/counter model.
    task automatic cycle(input bit iv, input logic [7:0] w, input bit cen,
                         input bit cdone, input bit ordy);
        bit e_acc, e_del;
        in_valid  = iv;
        in_data   = (iv && m_phase == P_LOAD) ? {8'h00, w} : '0;
        core_en   = cen;
        core_done = cdone;
        out_ready = ordy;
        #1;
        e_acc = (m_phase == P_LOAD) && iv;
        e_del = (m_phase == P_UNLOAD) && ordy;
        check("in_ready",   32'(in_ready),   32'(m_phase == P_LOAD));
        check("out_valid",  32'(out_valid),  32'(m_phase == P_UNLOAD));
        check("core_start", 32'(core_start), 32'(m_phase == P_START));
        check("scan_en",    32'(scan_en),    32'(e_acc || e_del));
        check("reg_en",     32'(reg_en),     32'(e_acc || e_del || (m_phase == P_RUN && cen)));
        check("scan_in",    32'(scan_in),    32'(in_data));
        check("out_data",   32'(out_data),   32'(scan_out));
        if (m_phase == P_UNLOAD) check("unload_word", 32'(out_data), 32'(chain_q[0]));
        @(posedge clk);
        if (e_acc || e_del) begin
            chain_q.push_back(in_data);
            void'(chain_q.pop_front());
        end
        case (m_phase)
            P_LOAD: if (iv) begin
                m_cnt++;
                if (m_cnt == NW) begin m_phase = P_START; m_cnt = 0; end
            end
            P_START: m_phase = P_RUN;
            P_RUN:   if (cdone) m_phase = P_UNLOAD;
            default: if (ordy) begin
                m_cnt++;
                if (m_cnt == NW) begin m_phase = P_LOAD; m_cnt = 0; end
            end
        endcase
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NW; i++) chain_q.push_back('0);

        //          iv cen cd ordy | ir ov cs se re
        tbl[0]  = '{0, 1, 1, 0,   1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,   1, 0, 0, 1, 1};
        tbl[2]  = '{1, 1, 0, 0,   0, 0, 1, 0, 0};
        tbl[3]  = '{0, 1, 0, 0,   0, 0, 0, 0, 1};
        tbl[4]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 0,   0, 0, 0, 0, 1};
        tbl[6]  = '{1, 1, 0, 0,   0, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 1,   0, 1, 0, 1, 1};
        tbl[8]  = '{0, 0, 1, 1,   1, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 0, 1,   1, 0, 0, 1, 1};
        tbl[10] = '{0, 0, 1, 0,   0, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 1, 0,   0, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 1,   0, 1, 0, 1, 1};
        tbl[13] = '{0, 0, 0, 0,   1, 0, 0, 0, 0};

        // Reset held with every input asserted: all control outputs must stay low.
        in_valid = 1'b1; out_ready = 1'b1; core_en = 1'b1; core_done = 1'b1;
        in_valid1 = 1'b1; out_ready1 = 1'b1; core_en1 = 1'b1;
        #3;
        check_all_low("por");
        check("por_in_ready1", 32'(in_ready1), 32'd0);
        check("por_reg_en1",   32'(reg_en1),   32'd0);
        #9;
        rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; core_en = 1'b0; core_done = 1'b0;

        // One-word chain: table of cycle-by-cycle vectors.
        for (int i = 0; i < 14; i++) begin
            in_valid1  = tbl[i].iv;
            core_en1   = tbl[i].cen;
            core_done1 = tbl[i].cdone;
            out_ready1 = tbl[i].ordy;
            in_data1   = tbl[i].iv ? {8'h00, 8'(i + 1)} : '0;
            scan_out1  = 16'($urandom);
            #1;
            check($sformatf("tbl%0d_in_ready", i),   32'(in_ready1),   32'(tbl[i].e_ir));
            check($sformatf("tbl%0d_out_valid", i),  32'(out_valid1),  32'(tbl[i].e_ov));
            check($sformatf("tbl%0d_core_start", i), 32'(core_start1), 32'(tbl[i].e_cs));
            check($sformatf("tbl%0d_scan_en", i),    32'(scan_en1),    32'(tbl[i].e_se));
            check($sformatf("tbl%0d_reg_en", i),     32'(reg_en1),     32'(tbl[i].e_re));
            check($sformatf("tbl%0d_scan_in", i),    32'(scan_in1),    32'(in_data1));
            check($sformatf("tbl%0d_out_data", i),   32'(out_data1),   32'(scan_out1));
            @(posedge clk);
            #1;
        end
        in_valid1 = 1'b0; core_en1 = 1'b0; core_done1 = 1'b0; out_ready1 = 1'b0; in_data1 = '0;

        // Full load of 1..16 with stray core_done/core_en, then RUN enable toggling.
        for (int k = 1; k <= NW; k++) cycle(1'b1, 8'(k), 1'b1, k == 3, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NW; k++) begin
            check("rt_word", 32'(out_data), 32'(k + 1));
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with back-pressure on both ports.
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom % 4) != 0, 8'($urandom), 1'($urandom), ($urandom % 5) == 0,
                  ($urandom % 3) != 0);
        end

        // Bring the DUT back to an empty LOAD, then reset after 7 accepts.
        for (int g = 0; g < 200 && !(m_phase == P_LOAD && m_cnt == 0); g++) begin
            cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b1);
        end
        check("drain_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 7; k++) cycle(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1; core_en = 1'b1; in_data = 16'h00AA;
        #1;
        rst = 1'b1;
        #1;
        check_all_low("async_rst");
        @(posedge clk);
        #1;
        check_all_low("held_rst");
        rst = 1'b0;
        m_phase = P_LOAD;
        m_cnt   = 0;
        for (int k = 0; k < NW; k++) cycle(1'b1, 8'(8'h80 + k), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NW; k++) begin
            check("post_rst_word", 32'(out_data), 32'(8'h80 + k));
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
